ps2_key_event: RTL and testbench
================================

# ps2_key_event

Downstream stage of the PS/2 receiver: pops raw scan-code bytes from the receiver FIFO through a ready/ack handshake and folds Set-2 prefix sequences (E0, F0, E0 F0) into single key events. Produces one-cycle key event strobes, tracks the currently held key, counts presses and flags protocol errors. Feeds the display/ASCII-lookup logic, replacing ad-hoc F0 detection in the receiver.

## Interface
- No parameters; byte codes and state encodings live in the package.
- `clk`  in  1  system clock
- `rst`  in  1  asynchronous, active-low reset
- `din`  in  8  scan-code byte at the head of the receiver FIFO
- `din_valid`  in  1  FIFO non-empty; `din` is valid
- `din_ack`  out  1  one-cycle pop strobe to the FIFO
- `key_valid`  out  1  one-cycle key event strobe
- `key_code`  out  8  base scan code of the last event (prefixes stripped); held between events
- `key_ext`  out  1  last event carried an E0 prefix
- `key_break`  out  1  last event was a release (F0)
- `key_held`  out  1  a key is currently down
- `held_code`  out  9  {ext, code} of the held key
- `press_count`  out  8  number of counted make events, modulo 256
- `err`  out  1  one-cycle protocol-error strobe

## Operation
- FSM states: IDLE, GOT_E0, GOT_F0, GOT_E0F0. Reset state is IDLE.
- IDLE:
  - E0 goes to GOT_E0.
  - F0 goes to GOT_F0.
  - Any other non-ignored byte emits a make event with ext=0.
- GOT_E0:
  - F0 goes to GOT_E0F0.
  - A non-prefix byte emits a make event with ext=1, then returns to IDLE.
- GOT_F0:
  - A non-prefix byte emits a break event with ext=0, then returns to IDLE.
- GOT_E0F0:
  - A non-prefix byte emits a break event with ext=1, then returns to IDLE.
- Protocol errors:
  - E0 or F0 arriving in GOT_F0 or GOT_E0F0, or E0 arriving in GOT_E0: pulse `err`, go to IDLE, emit no event.
  - E1 in any state: pulse `err`, go to IDLE. The Pause sequence is unsupported; its trailing bytes decode as ordinary codes.
- Ignored bytes (00, AA, EE, FA, FE, FF):
  - The byte is consumed and the state is unchanged.
  - No event and no `err`.
- Make event:
  - Set `key_held` and `held_code`.
  - Increment `press_count`, subject to Configuration.
- Break event:
  - If {ext, code} equals `held_code`, clear `key_held`.
  - Otherwise `key_held` is unchanged.
  - `press_count` is unchanged.
- A make of a different key while one is held overwrites `held_code`; only one held key is tracked.

## Timing
- Byte accept:
  - A byte is sampled on the rising edge where `din_valid`=1 and `din_ack`=0.
  - `din_ack` is registered and high for exactly the following cycle.
  - `din_valid` is ignored during that cycle, so throughput is at most one byte per 2 cycles.
- Output latency:
  - `key_valid`, `err`, and updates to `key_code`/`key_ext`/`key_break`/`held_code`/`key_held`/`press_count` are registered.
  - They become visible in the same cycle as `din_ack`.
- `key_valid` and `err` are never both high.
- Upstream must not change `din` while `din_valid`=1 and no ack has been given.
- Reset values: all outputs 0, FSM in IDLE. Reset mid-sequence (for example after E0) discards the partial prefix.
- `press_count` wraps from 255 to 0 with no flag.

## Configuration
- `KBD_TYPEMATIC_FILTER_EN` defined:
  - A make whose {ext, code} equals `held_code` while `key_held`=1 is a typematic repeat.
  - It is consumed with no `key_valid` and no `press_count` increment.
- `KBD_TYPEMATIC_FILTER_EN` undefined: every make emits `key_valid` and increments `press_count`.

## Structure
- Package `kbd_pkg` holds:
  - Constants SC_EXT=8'hE0, SC_BRK=8'hF0, SC_PAUSE=8'hE1.
  - The ignored-byte list.
  - The FSM state enum type.
- Sub-module `ps2_prefix_fsm`:
  - Contains the state register and next-state/decode logic only.
  - Outputs a decoded {make, break, ext, err} per accepted byte.
- The top level holds the handshake, output registers, held-key tracking and counter.

## Test plan
- 1C, F0 1C, one byte per 2 cycles:
  - Make event: `key_code`=1C, `key_break`=0, `key_held`=1, `press_count`=1.
  - Then break event: `key_break`=1, `key_held`=0.
- E0 75, then E0 F0 75:
  - Make event with `key_ext`=1, `held_code`=9'h175.
  - Then break event with ext=1, `key_held`=0.
- 1C 1C 1C (typematic), then F0 1C:
  - With the macro: one `key_valid`, `press_count`=1.
  - Without the macro: three `key_valid`, `press_count`=3.
- F0 E0 then 1C:
  - `err` pulses once on E0, state returns to IDLE.
  - 1C then emits a make with ext=0.
- AA then FA:
  - Each is acked with no `key_valid` and no `err`.
- 256 distinct make/break pairs: `press_count` wraps to 0.
- Assert `rst` after E0, release, send 1C: make event with ext=0.

Source files
------------

// File: rtl/kbd_pkg.sv
// Shared scan-code constants, ignored-byte list and prefix-FSM state type
// for the PS/2 key event stage.
package kbd_pkg;

    localparam logic [7:0] SC_EXT   = 8'hE0;
    localparam logic [7:0] SC_BRK   = 8'hF0;
    localparam logic [7:0] SC_PAUSE = 8'hE1;

    // Keyboard status/response bytes that carry no key information.
    localparam int unsigned NUM_IGNORED = 6;
    localparam logic [7:0] IGNORED_CODES [NUM_IGNORED] = '{
        8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hFF
    };

    typedef enum logic [1:0] {
        StIdle,
        StGotE0,
        StGotF0,
        StGotE0F0
    } kbd_state_e;

    function automatic logic is_ignored(input logic [7:0] b);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < NUM_IGNORED; i++) begin
            if (b == IGNORED_CODES[i]) hit = 1'b1;
        end
        return hit;
    endfunction

endpackage

// File: rtl/ps2_key_event_if.sv
// Byte-input handshake and key event outputs of the PS/2 key event stage.
// master: upstream FIFO / consumer side; slave: ps2_key_event.
interface ps2_key_event_if;

    logic [7:0] din;
    logic       din_valid;
    logic       din_ack;
    logic       key_valid;
    logic [7:0] key_code;
    logic       key_ext;
    logic       key_break;
    logic       key_held;
    logic [8:0] held_code;
    logic [7:0] press_count;
    logic       err;

    modport master (
        output din, din_valid,
        input  din_ack, key_valid, key_code, key_ext, key_break,
        input  key_held, held_code, press_count, err
    );

    modport slave (
        input  din, din_valid,
        output din_ack, key_valid, key_code, key_ext, key_break,
        output key_held, held_code, press_count, err
    );

endinterface

// File: rtl/ps2_prefix_fsm.sv
// Set-2 prefix folding FSM: tracks E0/F0 prefixes and decodes each accepted
// byte into {make, brk, ext, err}. Decode outputs are combinational and only
// meaningful while accept is high.
module ps2_prefix_fsm
    import kbd_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       accept,
    input  logic [7:0] din,
    output logic       make,
    output logic       brk,
    output logic       ext,
    output logic       err
);

    kbd_state_e state_q, state_d;

    // State register; only advances on an accepted byte.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
        end else if (accept) begin
            state_q <= state_d;
        end
    end

    // Next-state and per-byte decode.
    always_comb begin
        state_d = state_q;
        make    = 1'b0;
        brk     = 1'b0;
        ext     = 1'b0;
        err     = 1'b0;
        if (din == SC_PAUSE) begin
            err     = 1'b1;
            state_d = StIdle;
        end else if (!is_ignored(din)) begin
            unique case (state_q)
                StIdle: begin
                    if (din == SC_EXT)      state_d = StGotE0;
                    else if (din == SC_BRK) state_d = StGotF0;
                    else                    make = 1'b1;
                end
                StGotE0: begin
                    if (din == SC_BRK) begin
                        state_d = StGotE0F0;
                    end else if (din == SC_EXT) begin
                        err     = 1'b1;
                        state_d = StIdle;
                    end else begin
                        make    = 1'b1;
                        ext     = 1'b1;
                        state_d = StIdle;
                    end
                end
                StGotF0, StGotE0F0: begin
                    state_d = StIdle;
                    if (din == SC_EXT || din == SC_BRK) begin
                        err = 1'b1;
                    end else begin
                        brk = 1'b1;
                        ext = (state_q == StGotE0F0);
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

endmodule

// File: rtl/ps2_key_event.sv
// PS/2 key event stage: pops scan-code bytes with a registered one-cycle ack,
// folds prefixes into key events, tracks the held key and counts presses.
// Optional feature: KBD_TYPEMATIC_FILTER_EN suppresses typematic repeats.
module ps2_key_event
    import kbd_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    ps2_key_event_if.slave   bus
);

    logic       accept;
    logic       dec_make, dec_brk, dec_ext, dec_err;
    logic       is_repeat;
    logic [8:0] ev_code;

    logic       ack_q;
    logic       key_valid_q;
    logic       err_q;
    logic [7:0] key_code_q;
    logic       key_ext_q;
    logic       key_break_q;
    logic       held_q;
    logic [8:0] held_code_q;
    logic [7:0] press_count_q;

    // din_valid is ignored while the ack is out, giving one byte per 2 cycles.
    assign accept  = bus.din_valid & ~ack_q;
    assign ev_code = {dec_ext, bus.din};

    ps2_prefix_fsm u_fsm (
        .clk    (clk),
        .rst    (rst),
        .accept (accept),
        .din    (bus.din),
        .make   (dec_make),
        .brk    (dec_brk),
        .ext    (dec_ext),
        .err    (dec_err)
    );

    // Typematic repeat detection (make of the key already held).
    always_comb begin
`ifdef KBD_TYPEMATIC_FILTER_EN
        is_repeat = held_q && (held_code_q == ev_code);
`else
        is_repeat = 1'b0;
`endif
    end

    // Handshake, event strobes, held-key tracking and press counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ack_q         <= 1'b0;
            key_valid_q   <= 1'b0;
            err_q         <= 1'b0;
            key_code_q    <= 8'h00;
            key_ext_q     <= 1'b0;
            key_break_q   <= 1'b0;
            held_q        <= 1'b0;
            held_code_q   <= 9'h000;
            press_count_q <= 8'h00;
        end else begin
            ack_q       <= accept;
            key_valid_q <= 1'b0;
            err_q       <= 1'b0;
            if (accept) begin
                if (dec_err) begin
                    err_q <= 1'b1;
                end else if (dec_make && !is_repeat) begin
                    key_valid_q   <= 1'b1;
                    key_code_q    <= bus.din;
                    key_ext_q     <= dec_ext;
                    key_break_q   <= 1'b0;
                    held_q        <= 1'b1;
                    held_code_q   <= ev_code;
                    press_count_q <= press_count_q + 8'd1;
                end else if (dec_brk) begin
                    key_valid_q <= 1'b1;
                    key_code_q  <= bus.din;
                    key_ext_q   <= dec_ext;
                    key_break_q <= 1'b1;
                    if (held_code_q == ev_code) held_q <= 1'b0;
                end
            end
        end
    end

    assign bus.din_ack     = ack_q;
    assign bus.key_valid   = key_valid_q;
    assign bus.err         = err_q;
    assign bus.key_code    = key_code_q;
    assign bus.key_ext     = key_ext_q;
    assign bus.key_break   = key_break_q;
    assign bus.key_held    = held_q;
    assign bus.held_code   = held_code_q;
    assign bus.press_count = press_count_q;

endmodule

// File: tb/tb_ps2_key_event.sv
// Directed bench for ps2_key_event. Honours KBD_TYPEMATIC_FILTER_EN when set.
module tb_ps2_key_event;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    logic last_kv;
    logic last_err;

    ps2_key_event_if bus ();

    ps2_key_event dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        bus.din_valid = 1'b0;
        bus.din = 8'h00;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    // Present one byte, wait (bounded) for its ack, capture strobes in the ack cycle.
    task automatic send_byte(input logic [7:0] b);
        bit got;
        got = 1'b0;
        @(negedge clk);
        bus.din = b;
        bus.din_valid = 1'b1;
        for (int i = 0; i < 8 && !got; i++) begin
            @(posedge clk);
            #1;
            if (bus.din_ack === 1'b1) got = 1'b1;
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL ack_timeout byte=%h: din_ack got 0 required 1", b);
        end
        last_kv  = bus.key_valid;
        last_err = bus.err;
        @(negedge clk);
        bus.din_valid = 1'b0;
    endtask

    task automatic test_reset();
        logic [35:0] all_out;
        rst = 1'b0;
        bus.din_valid = 1'b0;
        bus.din = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        all_out = {bus.din_ack, bus.key_valid, bus.key_code, bus.key_ext, bus.key_break,
                   bus.key_held, bus.held_code, bus.press_count, bus.err};
        checks++;
        if (all_out !== 36'h0) begin
            errors++;
            $display("FAIL reset_outputs: got %h required 0", all_out);
        end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_make_break();
        send_byte(8'h1C);
        checks++;
        if ({last_kv, bus.key_code, bus.key_break, bus.key_ext, bus.key_held, bus.press_count}
            !== {1'b1, 8'h1C, 1'b0, 1'b0, 1'b1, 8'd1}) begin
            errors++;
            $display("FAIL make_1c: kv=%b code=%h brk=%b ext=%b held=%b cnt=%0d required 1 1c 0 0 1 1",
                     last_kv, bus.key_code, bus.key_break, bus.key_ext, bus.key_held,
                     bus.press_count);
        end
        send_byte(8'hF0);
        checks++;
        if ({last_kv, last_err} !== 2'b00) begin
            errors++;
            $display("FAIL f0_prefix_quiet: kv=%b err=%b required 0 0", last_kv, last_err);
        end
        send_byte(8'h1C);
        checks++;
        if ({last_kv, bus.key_code, bus.key_break, bus.key_held, bus.press_count}
            !== {1'b1, 8'h1C, 1'b1, 1'b0, 8'd1}) begin
            errors++;
            $display("FAIL break_1c: kv=%b code=%h brk=%b held=%b cnt=%0d required 1 1c 1 0 1",
                     last_kv, bus.key_code, bus.key_break, bus.key_held, bus.press_count);
        end
    endtask

    task automatic test_ext();
        send_byte(8'hE0);
        send_byte(8'h75);
        checks++;
        if ({last_kv, bus.key_ext, bus.key_break, bus.key_held, bus.held_code, bus.press_count}
            !== {1'b1, 1'b1, 1'b0, 1'b1, 9'h175, 8'd2}) begin
            errors++;
            $display("FAIL make_e075: kv=%b ext=%b brk=%b held=%b hc=%h cnt=%0d required 1 1 0 1 175 2",
                     last_kv, bus.key_ext, bus.key_break, bus.key_held, bus.held_code,
                     bus.press_count);
        end
        send_byte(8'hE0);
        send_byte(8'hF0);
        send_byte(8'h75);
        checks++;
        if ({last_kv, bus.key_code, bus.key_ext, bus.key_break, bus.key_held}
            !== {1'b1, 8'h75, 1'b1, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL break_e0f075: kv=%b code=%h ext=%b brk=%b held=%b required 1 75 1 1 0",
                     last_kv, bus.key_code, bus.key_ext, bus.key_break, bus.key_held);
        end
    endtask

    task automatic test_typematic();
        int kv_count;
        int exp_count;
        logic [7:0] cnt0;
        logic [7:0] exp_cnt;
`ifdef KBD_TYPEMATIC_FILTER_EN
        exp_count = 1;
`else
        exp_count = 3;
`endif
        cnt0 = 8'd2;
        kv_count = 0;
        for (int i = 0; i < 3; i++) begin
            send_byte(8'h1C);
            if (last_kv) kv_count++;
        end
        exp_cnt = cnt0 + 8'(exp_count);
        checks++;
        if (kv_count != exp_count || bus.press_count !== exp_cnt) begin
            errors++;
            $display("FAIL typematic: kv_count=%0d cnt=%0d required %0d %0d",
                     kv_count, bus.press_count, exp_count, exp_cnt);
        end
        send_byte(8'hF0);
        send_byte(8'h1C);
        checks++;
        if ({last_kv, bus.key_break, bus.key_held} !== 3'b110) begin
            errors++;
            $display("FAIL typematic_release: kv=%b brk=%b held=%b required 1 1 0",
                     last_kv, bus.key_break, bus.key_held);
        end
    endtask

    task automatic test_errors();
        send_byte(8'hF0);
        send_byte(8'hE0);
        checks++;
        if ({last_err, last_kv} !== 2'b10) begin
            errors++;
            $display("FAIL err_f0e0: err=%b kv=%b required 1 0", last_err, last_kv);
        end
        @(posedge clk);
        #1;
        checks++;
        if (bus.err !== 1'b0) begin
            errors++;
            $display("FAIL err_one_cycle: err=%b required 0", bus.err);
        end
        send_byte(8'h1C);
        checks++;
        if ({last_kv, last_err, bus.key_ext, bus.key_break, bus.key_held} !== 5'b10001) begin
            errors++;
            $display("FAIL make_after_err: kv=%b err=%b ext=%b brk=%b held=%b required 1 0 0 0 1",
                     last_kv, last_err, bus.key_ext, bus.key_break, bus.key_held);
        end
        send_byte(8'hF0);
        send_byte(8'h1C);
        send_byte(8'hE0);
        send_byte(8'hE1);
        checks++;
        if ({last_err, last_kv} !== 2'b10) begin
            errors++;
            $display("FAIL err_e1: err=%b kv=%b required 1 0", last_err, last_kv);
        end
        send_byte(8'h14);
        checks++;
        if ({last_kv, bus.key_code, bus.key_ext} !== {1'b1, 8'h14, 1'b0}) begin
            errors++;
            $display("FAIL make_after_e1: kv=%b code=%h ext=%b required 1 14 0",
                     last_kv, bus.key_code, bus.key_ext);
        end
        send_byte(8'hF0);
        send_byte(8'h14);
    endtask

    task automatic test_ignored();
        logic [7:0] cnt0;
        cnt0 = bus.press_count;
        send_byte(8'hAA);
        checks++;
        if ({last_kv, last_err} !== 2'b00) begin
            errors++;
            $display("FAIL ignored_aa: kv=%b err=%b required 0 0", last_kv, last_err);
        end
        send_byte(8'hFA);
        checks++;
        if ({last_kv, last_err} !== 2'b00) begin
            errors++;
            $display("FAIL ignored_fa: kv=%b err=%b required 0 0", last_kv, last_err);
        end
        // An ignored byte between prefix and code must not disturb the prefix.
        send_byte(8'hE0);
        send_byte(8'hFE);
        send_byte(8'h75);
        checks++;
        if ({last_kv, bus.key_ext, bus.key_break, bus.held_code} !== {1'b1, 1'b1, 1'b0, 9'h175}) begin
            errors++;
            $display("FAIL ignored_mid_prefix: kv=%b ext=%b brk=%b hc=%h required 1 1 0 175",
                     last_kv, bus.key_ext, bus.key_break, bus.held_code);
        end
        checks++;
        if (bus.press_count !== cnt0 + 8'd1) begin
            errors++;
            $display("FAIL ignored_count: cnt=%0d required %0d", bus.press_count, cnt0 + 8'd1);
        end
        send_byte(8'hE0);
        send_byte(8'hF0);
        send_byte(8'h75);
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        bus.din = 8'h1C;
        bus.din_valid = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if ({bus.din_ack, bus.key_valid, bus.key_code} !== {1'b1, 1'b1, 8'h1C}) begin
            errors++;
            $display("FAIL b2b_first: ack=%b kv=%b code=%h required 1 1 1c",
                     bus.din_ack, bus.key_valid, bus.key_code);
        end
        @(negedge clk);
        bus.din = 8'h32;
        @(posedge clk);
        #1;
        checks++;
        if ({bus.din_ack, bus.key_valid} !== 2'b00) begin
            errors++;
            $display("FAIL b2b_gap: ack=%b kv=%b required 0 0", bus.din_ack, bus.key_valid);
        end
        @(posedge clk);
        #1;
        checks++;
        if ({bus.din_ack, bus.key_valid, bus.key_code, bus.held_code}
            !== {1'b1, 1'b1, 8'h32, 9'h032}) begin
            errors++;
            $display("FAIL b2b_second: ack=%b kv=%b code=%h hc=%h required 1 1 32 032",
                     bus.din_ack, bus.key_valid, bus.key_code, bus.held_code);
        end
        @(negedge clk);
        bus.din_valid = 1'b0;
        // Releasing a key other than the held one leaves key_held set.
        send_byte(8'hF0);
        send_byte(8'h1C);
        checks++;
        if ({last_kv, bus.key_held} !== 2'b11) begin
            errors++;
            $display("FAIL release_other: kv=%b held=%b required 1 1", last_kv, bus.key_held);
        end
        send_byte(8'hF0);
        send_byte(8'h32);
        checks++;
        if (bus.key_held !== 1'b0) begin
            errors++;
            $display("FAIL release_held: held=%b required 0", bus.key_held);
        end
    endtask

    task automatic test_reset_mid();
        send_byte(8'hE0);
        do_reset();
        send_byte(8'h1C);
        checks++;
        if ({last_kv, bus.key_ext, bus.key_break, bus.held_code, bus.press_count}
            !== {1'b1, 1'b0, 1'b0, 9'h01C, 8'd1}) begin
            errors++;
            $display("FAIL reset_mid_e0: kv=%b ext=%b brk=%b hc=%h cnt=%0d required 1 0 0 01c 1",
                     last_kv, bus.key_ext, bus.key_break, bus.held_code, bus.press_count);
        end
    endtask

    task automatic test_wrap();
        logic [7:0] code;
        do_reset();
        for (int i = 0; i < 256; i++) begin
            code = 8'h01 + 8'(i % 112);
            send_byte(code);
            send_byte(8'hF0);
            send_byte(code);
            if (i == 254) begin
                checks++;
                if (bus.press_count !== 8'd255) begin
                    errors++;
                    $display("FAIL count_255: cnt=%0d required 255", bus.press_count);
                end
            end
        end
        checks++;
        if (bus.press_count !== 8'd0) begin
            errors++;
            $display("FAIL count_wrap: cnt=%0d required 0", bus.press_count);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        last_kv = 1'b0;
        last_err = 1'b0;
        rst = 1'b0;
        bus.din = 8'h00;
        bus.din_valid = 1'b0;
        test_reset();
        test_make_break();
        test_ext();
        test_typematic();
        test_errors();
        test_ignored();
        test_back_to_back();
        test_reset_mid();
        test_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
